// File: rtl/multicycle_seq32_if.sv
// rtl/multicycle_seq32_if.sv - decoder/datapath <-> sequencer signal bundle
interface multicycle_seq32_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [21:0] alu_result_high;
    logic        zero;
    logic        io_ready;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        io_read;
    logic        io_write;
    logic        io_err;
    logic [2:0]  state;

    modport master (
        input  opcode, funct, alu_result_high, zero, io_ready,
        output pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
               io_read, io_write, io_err, state
    );

    modport slave (
        output opcode, funct, alu_result_high, zero, io_ready,
        input  pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
               io_read, io_write, io_err, state
    );
endinterface

// File: rtl/multicycle_seq32.sv
// rtl/multicycle_seq32.sv - multi-cycle IF/ID/EX/MEM/WB sequencer, optional IO timeout via MC_IO_TIMEOUT_EN
module multicycle_seq32 #(
    parameter int          IO_TIMEOUT = 64,
    parameter logic [21:0] IO_PAGE    = 22'h3FFFFF
) (
    input  logic               clock,
    input  logic               rst_n,
    multicycle_seq32_if.master bus
);

    typedef enum logic [2:0] {
        S_IF     = 3'd0,
        S_ID     = 3'd1,
        S_EX     = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_IOWAIT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t     state_q;
    state_t     state_d;
    logic       pc_write_c;
    logic [1:0] pc_src_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       io_read_c;
    logic       io_write_c;
    logic       io_err_c;

    logic is_lw;
    logic is_sw;
    logic is_io;
    logic unused_cfg;

    assign is_lw      = (bus.opcode == OP_LW);
    assign is_sw      = (bus.opcode == OP_SW);
    assign is_io      = (bus.alu_result_high == IO_PAGE);
    assign unused_cfg = (IO_TIMEOUT > 0);

`ifdef MC_IO_TIMEOUT_EN
    localparam int CNT_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    logic [CNT_W-1:0] io_cnt;
    logic             io_expired;
    assign io_expired = (io_cnt == CNT_W'(IO_TIMEOUT - 1));
`endif

    always_comb begin
        state_d     = S_IF;
        pc_write_c  = 1'b0;
        pc_src_c    = 2'd0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        io_read_c   = 1'b0;
        io_write_c  = 1'b0;
        io_err_c    = 1'b0;
        case (state_q)
            S_IF: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                state_d    = S_ID;
            end
            S_ID: begin
                if (bus.opcode == OP_J) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'd2;
                end else if (bus.opcode == OP_RTYPE && bus.funct == FN_JR) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'd3;
                end else if (bus.opcode == OP_JAL) begin
                    // jal links $31 straight from ID, skipping EX
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'd2;
                    state_d    = S_WB;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if ((bus.opcode == OP_BEQ && bus.zero) || (bus.opcode == OP_BNE && !bus.zero)) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'd1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (bus.opcode == OP_RTYPE || bus.opcode[5:3] == 3'b001) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (is_io) begin
                    io_read_c  = is_lw;
                    io_write_c = is_sw;
                    if (!bus.io_ready)
                        state_d = S_IOWAIT;
                    else if (is_lw)
                        state_d = S_WB;
                end else begin
                    mem_read_c  = is_lw;
                    mem_write_c = is_sw;
                    if (is_lw)
                        state_d = S_WB;
                end
            end
            S_IOWAIT: begin
                io_read_c  = is_lw;
                io_write_c = is_sw;
                if (bus.io_ready) begin
                    if (is_lw)
                        state_d = S_WB;
                end else begin
                    state_d = S_IOWAIT;
`ifdef MC_IO_TIMEOUT_EN
                    // abort: strobe withdrawn in the error cycle, lw never reaches WB
                    if (io_expired) begin
                        io_err_c   = 1'b1;
                        io_read_c  = 1'b0;
                        io_write_c = 1'b0;
                        state_d    = S_IF;
                    end
`endif
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IF;
        else
            state_q <= state_d;
    end

`ifdef MC_IO_TIMEOUT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            io_cnt <= '0;
        else if (state_d == S_MEM)
            io_cnt <= '0;
        else if (state_q == S_IOWAIT)
            io_cnt <= io_cnt + CNT_W'(1);
    end
`endif

    // Gate with rst_n so every strobe drops the moment reset asserts
    assign bus.pc_write  = rst_n & pc_write_c;
    assign bus.pc_src    = rst_n ? pc_src_c : 2'd0;
    assign bus.ir_write  = rst_n & ir_write_c;
    assign bus.reg_write = rst_n & reg_write_c;
    assign bus.mem_read  = rst_n & mem_read_c;
    assign bus.mem_write = rst_n & mem_write_c;
    assign bus.io_read   = rst_n & io_read_c;
    assign bus.io_write  = rst_n & io_write_c;
    assign bus.io_err    = rst_n & io_err_c & unused_cfg;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_seq32.sv
// tb/tb_multicycle_seq32.sv - directed bench for multicycle_seq32 (timeout case under MC_IO_TIMEOUT_EN)
module tb_multicycle_seq32;

`ifdef MC_IO_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    // strobe vector: {pc_write, pc_src[1:0], ir_write, reg_write, mem_read, mem_write, io_read, io_write, io_err}
    localparam logic [9:0] NONE = 10'h000;
    localparam logic [9:0] PCW  = 10'h200;
    localparam logic [9:0] SRC1 = 10'h080;
    localparam logic [9:0] SRC2 = 10'h100;
    localparam logic [9:0] SRC3 = 10'h180;
    localparam logic [9:0] IRW  = 10'h040;
    localparam logic [9:0] RW   = 10'h020;
    localparam logic [9:0] MR   = 10'h010;
    localparam logic [9:0] MW   = 10'h008;
    localparam logic [9:0] IOR  = 10'h004;
    localparam logic [9:0] IOW  = 10'h002;
    localparam logic [9:0] ERR  = 10'h001;
    localparam logic [9:0] FETCH = PCW | IRW;

    logic clock;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    multicycle_seq32_if bus();

    multicycle_seq32 #(.IO_TIMEOUT(TO), .IO_PAGE(22'h3FFFFF)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [9:0] strobes();
        return {bus.pc_write, bus.pc_src, bus.ir_write, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.io_read, bus.io_write, bus.io_err};
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // check the current cycle, then advance to 1ns past the next rising edge
    task automatic step(input string tag, input logic [2:0] st, input logic [9:0] exp);
        logic [9:0] mem_io;
        check({tag, "_state"}, {7'd0, bus.state}, {7'd0, st});
        check({tag, "_strobes"}, strobes(), exp);
        mem_io = {6'd0, bus.mem_read, bus.mem_write, bus.io_read, bus.io_write};
        check({tag, "_onehot"}, 10'($countones(mem_io) <= 1), 10'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input logic [21:0] addr, input logic rdy);
        bus.opcode          = op;
        bus.funct           = fn;
        bus.zero            = z;
        bus.alu_result_high = addr;
        bus.io_ready        = rdy;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        set_in(6'h00, 6'h00, 1'b0, 22'h0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", {7'd0, bus.state}, 10'd0);
        check("rst_strobes", strobes(), NONE);
        rst_n = 1'b1;
        #1;

        // add: 0,1,2,4,0
        set_in(6'h00, 6'h20, 1'b0, 22'h0, 1'b0);
        step("add_if", 3'd0, FETCH);
        step("add_id", 3'd1, NONE);
        step("add_ex", 3'd2, NONE);
        step("add_wb", 3'd4, RW);

        // beq taken / not taken
        set_in(6'h04, 6'h00, 1'b1, 22'h0, 1'b0);
        step("beq1_if", 3'd0, FETCH);
        step("beq1_id", 3'd1, NONE);
        step("beq1_ex", 3'd2, PCW | SRC1);
        set_in(6'h04, 6'h00, 1'b0, 22'h0, 1'b0);
        step("beq0_if", 3'd0, FETCH);
        step("beq0_id", 3'd1, NONE);
        step("beq0_ex", 3'd2, NONE);

        // bne taken when zero=0
        set_in(6'h05, 6'h00, 1'b0, 22'h0, 1'b0);
        step("bne_if", 3'd0, FETCH);
        step("bne_id", 3'd1, NONE);
        step("bne_ex", 3'd2, PCW | SRC1);

        // lw from RAM
        set_in(6'h23, 6'h00, 1'b0, 22'h000001, 1'b0);
        step("lw_if", 3'd0, FETCH);
        step("lw_id", 3'd1, NONE);
        step("lw_ex", 3'd2, NONE);
        step("lw_mem", 3'd3, MR);
        step("lw_wb", 3'd4, RW);

        // sw to RAM
        set_in(6'h2B, 6'h00, 1'b0, 22'h000010, 1'b0);
        step("swr_if", 3'd0, FETCH);
        step("swr_id", 3'd1, NONE);
        step("swr_ex", 3'd2, NONE);
        step("swr_mem", 3'd3, MW);

        // sw to IO: ready low 5 cycles, high on the 6th
        set_in(6'h2B, 6'h00, 1'b0, 22'h3FFFFF, 1'b0);
        step("swio_if", 3'd0, FETCH);
        step("swio_id", 3'd1, NONE);
        step("swio_ex", 3'd2, NONE);
        step("swio_mem", 3'd3, IOW);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) set_in(6'h2B, 6'h00, 1'b0, 22'h3FFFFF, 1'b1);
            step("swio_wait", 3'd5, IOW);
        end

        // lw from IO, ready in MEM
        set_in(6'h23, 6'h00, 1'b0, 22'h3FFFFF, 1'b1);
        step("lwio_if", 3'd0, FETCH);
        step("lwio_id", 3'd1, NONE);
        step("lwio_ex", 3'd2, NONE);
        step("lwio_mem", 3'd3, IOR);
        step("lwio_wb", 3'd4, RW);

        // jumps
        set_in(6'h02, 6'h00, 1'b0, 22'h0, 1'b0);
        step("j_if", 3'd0, FETCH);
        step("j_id", 3'd1, PCW | SRC2);
        set_in(6'h00, 6'h08, 1'b0, 22'h0, 1'b0);
        step("jr_if", 3'd0, FETCH);
        step("jr_id", 3'd1, PCW | SRC3);
        set_in(6'h03, 6'h00, 1'b0, 22'h0, 1'b0);
        step("jal_if", 3'd0, FETCH);
        step("jal_id", 3'd1, PCW | SRC2);
        step("jal_wb", 3'd4, RW);

        // addi goes to WB; unknown opcode returns to IF silently
        set_in(6'h08, 6'h00, 1'b0, 22'h0, 1'b0);
        step("addi_if", 3'd0, FETCH);
        step("addi_id", 3'd1, NONE);
        step("addi_ex", 3'd2, NONE);
        step("addi_wb", 3'd4, RW);
        set_in(6'h3F, 6'h00, 1'b0, 22'h0, 1'b0);
        step("bad_if", 3'd0, FETCH);
        step("bad_id", 3'd1, NONE);
        step("bad_ex", 3'd2, NONE);

        // reset asserted in WB: strobes drop asynchronously
        set_in(6'h00, 6'h20, 1'b0, 22'h0, 1'b0);
        step("mr_if", 3'd0, FETCH);
        step("mr_id", 3'd1, NONE);
        step("mr_ex", 3'd2, NONE);
        check("mr_wb_pre", strobes(), RW);
        rst_n = 1'b0;
        #1;
        check("mr_async_strobes", strobes(), NONE);
        check("mr_async_state", {7'd0, bus.state}, 10'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        #1;
        step("mr_resume_if", 3'd0, FETCH);
        step("mr_resume_id", 3'd1, NONE);
        step("mr_resume_ex", 3'd2, NONE);
        step("mr_resume_wb", 3'd4, RW);

`ifdef MC_IO_TIMEOUT_EN
        // lw to IO with ready stuck low: error in the 8th IOWAIT cycle, no WB
        set_in(6'h23, 6'h00, 1'b0, 22'h3FFFFF, 1'b0);
        step("to_if", 3'd0, FETCH);
        step("to_id", 3'd1, NONE);
        step("to_ex", 3'd2, NONE);
        step("to_mem", 3'd3, IOR);
        for (int k = 1; k < TO; k++)
            step("to_wait", 3'd5, IOR);
        step("to_err", 3'd5, ERR);
        step("to_after_if", 3'd0, FETCH);
        step("to_after_id", 3'd1, NONE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
